// File: rtl/multiplier_pkg.sv
// Shared definitions for the serial shift-and-add multiplier: state encoding,
// default operand width and the counter-width helper.
package multiplier_pkg;

  localparam int DEFAULT_WORD_LENGTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Never returns zero so a one-bit operand still gets a legal counter.
  function automatic int counterWidth(input int wordLength);
    return (wordLength > 1) ? $clog2(wordLength) : 1;
  endfunction

endpackage

// File: rtl/shift_add_accumulator.sv
// Accumulator register and add/shift datapath: adds the multiplicand into the
// upper bits when the serial bit is set, then shifts the whole register right.
module shift_add_accumulator
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic                     bit_in_i,
  input  logic [WORD_LENGTH-1:0]   multiplicand_i,
  output logic [2*WORD_LENGTH:0]   acc_o,
  output logic [2*WORD_LENGTH:0]   acc_next_o
);

  logic [2*WORD_LENGTH:0] acc_q;
  logic [2*WORD_LENGTH:0] acc_d;
  logic [WORD_LENGTH:0]   upperSum;

  // The upper slice is WORD_LENGTH+1 bits so the add carry survives the shift.
  always_comb begin
    upperSum = acc_q[2*WORD_LENGTH:WORD_LENGTH]
             + (bit_in_i ? {1'b0, multiplicand_i} : '0);
    acc_d    = {upperSum, acc_q[WORD_LENGTH-1:0]} >> 1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      acc_q <= '0;
    end else if (enable_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o      = acc_q;
  assign acc_next_o = acc_d;

endmodule

// File: rtl/serial_shift_add_multiplier.sv
// Sequential unsigned multiplier: consumes the multiplier LSB-first on bit_in_i,
// one bit per clock, and registers the 2*WORD_LENGTH-bit product with a done pulse.
module serial_shift_add_multiplier
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [WORD_LENGTH-1:0]     multiplicand_i,
  input  logic                       bit_in_i,
  output logic [2*WORD_LENGTH-1:0]   product_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int CNT_W = counterWidth(WORD_LENGTH);

  state_t                   state_q;
  logic [CNT_W-1:0]         count_q;
  logic [WORD_LENGTH-1:0]   multiplicand_q;
  logic [2*WORD_LENGTH-1:0] product_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     accept;
  logic                     lastBit;
  logic [2*WORD_LENGTH:0]   acc;
  logic [2*WORD_LENGTH:0]   accNext;

  // A start is honoured only when not mid-operation.
  assign accept  = start_i && (state_q != RUN);
  assign lastBit = (count_q == CNT_W'(WORD_LENGTH - 1));

  shift_add_accumulator #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_accumulator (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .clear_i        (accept),
    .enable_i       (state_q == RUN),
    .bit_in_i       (bit_in_i),
    .multiplicand_i (multiplicand_q),
    .acc_o          (acc),
    .acc_next_o     (accNext)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      count_q        <= '0;
      multiplicand_q <= '0;
      product_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          count_q <= count_q + 1'b1;
          // The product is taken from the accumulator's next value so it lands on the same edge.
          if (lastBit) begin
            product_q <= accNext[2*WORD_LENGTH-1:0];
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (accept) begin
            multiplicand_q <= multiplicand_i;
            count_q        <= '0;
            state_q        <= RUN;
            busy_q         <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign product_o = product_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule
